// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the convolution loop-nest controller.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    MAC    = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Counter width for an extent; a single-value loop still gets one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Linear psum address: (x*height + y)*out_ch + ch.
  function automatic logic [31:0] psum_addr(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic [31:0] ch,
                                            input logic [31:0] height,
                                            input logic [31:0] out_ch);
    return (x * height + y) * out_ch + ch;
  endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear; shifts every cycle.
module ctrl_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_loop_ctrl.sv
// Loop-nest controller: operand fetch sequencing, psum addressing, output coordinates.
// Optional CONV_LOOP_CTRL_PERF_EN adds perf_busy / perf_stall cycle counters.
module conv_loop_ctrl import conv_ctrl_pkg::*; #(
  parameter int FEATURE_MAP_WIDTH  = 16,
  parameter int FEATURE_MAP_HEIGHT = 16,
  parameter int INPUT_NB_CHANNELS  = 8,
  parameter int OUTPUT_NB_CHANNELS = 8,
  parameter int KERNEL_SIZE        = 3,
  parameter int WEIGHT_WORDS       = 2,
  parameter int ACT_WORDS          = 2,
  parameter int MAC_LATENCY        = 5,
  parameter int LOG2_OF_MEM_HEIGHT = 20
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          start,
  output logic                          running,
  input  logic                          valid,
  output logic                          ready,
  output logic [WEIGHT_WORDS-1:0]       write_w,
  output logic [ACT_WORDS-1:0]          write_a,
  output logic                          mac_valid,
  output logic                          mac_accumulate_with_0,
  output logic                          mem_re,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
  output logic                          mem_we,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_write_addr,
  output logic                          output_valid,
  output logic [31:0]                   output_x,
  output logic [31:0]                   output_y,
  output logic [31:0]                   output_ch
`ifdef CONV_LOOP_CTRL_PERF_EN
  ,
  output logic [31:0]                   perf_busy,
  output logic [31:0]                   perf_stall
`endif
);

  localparam int XW  = cnt_w(FEATURE_MAP_WIDTH);
  localparam int YW  = cnt_w(FEATURE_MAP_HEIGHT);
  localparam int CIW = cnt_w(INPUT_NB_CHANNELS);
  localparam int COW = cnt_w(OUTPUT_NB_CHANNELS);
  localparam int KW  = cnt_w(KERNEL_SIZE);
  localparam int WW  = cnt_w((WEIGHT_WORDS > ACT_WORDS) ? WEIGHT_WORDS : ACT_WORDS);
  localparam int DCW = cnt_w(MAC_LATENCY);
  localparam int DLW = XW + YW + COW + 2;

  state_e          state_q, state_d;
  logic [WW-1:0]   w_q, w_d;
  logic [DCW-1:0]  dc_q, dc_d;
  logic [CIW-1:0]  ci_q, ci_d, ci_n;
  logic [KW-1:0]   ky_q, ky_d, ky_n, kx_q, kx_d, kx_n;
  logic [XW-1:0]   x_q, x_d, x_n;
  logic [YW-1:0]   y_q, y_d, y_n;
  logic [COW-1:0]  co_q, co_d, co_n;

  logic ci_max_s, ky_max_s, kx_max_s, x_max_s, y_max_s, co_max_s;
  logic spatial_wrap_s, tap_last_s, first_s;
  logic [DLW-1:0] dl_out_s;
  logic [XW-1:0]  dl_x_s;
  logic [YW-1:0]  dl_y_s;
  logic [COW-1:0] dl_co_s;
  logic           dl_last_s, dl_v_s;

  assign ci_max_s = (ci_q == CIW'(INPUT_NB_CHANNELS - 1));
  assign ky_max_s = (ky_q == KW'(KERNEL_SIZE - 1));
  assign kx_max_s = (kx_q == KW'(KERNEL_SIZE - 1));
  assign x_max_s  = (x_q == XW'(FEATURE_MAP_WIDTH - 1));
  assign y_max_s  = (y_q == YW'(FEATURE_MAP_HEIGHT - 1));
  assign co_max_s = (co_q == COW'(OUTPUT_NB_CHANNELS - 1));

  assign spatial_wrap_s = x_max_s && y_max_s && co_max_s;
  assign tap_last_s     = ci_max_s && ky_max_s && kx_max_s;
  assign first_s        = (ci_q == '0) && (ky_q == '0) && (kx_q == '0);

  // Ripple-carry of the loop nest, innermost ch_out first.
  always_comb begin
    co_n = co_max_s ? '0 : co_q + 1'b1;
    y_n  = !co_max_s ? y_q : (y_max_s ? '0 : y_q + 1'b1);
    x_n  = !(co_max_s && y_max_s) ? x_q : (x_max_s ? '0 : x_q + 1'b1);
    kx_n = !spatial_wrap_s ? kx_q : (kx_max_s ? '0 : kx_q + 1'b1);
    ky_n = !(spatial_wrap_s && kx_max_s) ? ky_q : (ky_max_s ? '0 : ky_q + 1'b1);
    ci_n = !(spatial_wrap_s && kx_max_s && ky_max_s) ? ci_q : (ci_max_s ? '0 : ci_q + 1'b1);
  end

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    dc_d      = dc_q;
    ci_d      = ci_q;
    ky_d      = ky_q;
    kx_d      = kx_q;
    x_d       = x_q;
    y_d       = y_q;
    co_d      = co_q;
    ready     = 1'b0;
    mac_valid = 1'b0;
    case (state_q)
      IDLE: state_d = start ? LOAD_W : IDLE;
      LOAD_W: begin
        ready = 1'b1;
        if (valid) begin
          if (w_q == WW'(WEIGHT_WORDS - 1)) begin
            w_d     = '0;
            state_d = MAC;
          end else begin
            w_d = w_q + 1'b1;
          end
        end else begin
          w_d = w_q;
        end
      end
      MAC: begin
        ready = 1'b1;
        if (valid) begin
          if (w_q == WW'(ACT_WORDS - 1)) begin
            w_d       = '0;
            mac_valid = 1'b1;
            ci_d      = ci_n;
            ky_d      = ky_n;
            kx_d      = kx_n;
            x_d       = x_n;
            y_d       = y_n;
            co_d      = co_n;
            if (spatial_wrap_s) begin
              state_d = tap_last_s ? DRAIN : LOAD_W;
            end else begin
              state_d = MAC;
            end
          end else begin
            w_d = w_q + 1'b1;
          end
        end else begin
          w_d = w_q;
        end
      end
      DRAIN: begin
        if (dc_q == DCW'(MAC_LATENCY - 1)) begin
          dc_d    = '0;
          state_d = DONE;
        end else begin
          dc_d = dc_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register strobes are only raised for a word actually being transferred.
  always_comb begin
    write_w = '0;
    write_a = '0;
    for (int i = 0; i < WEIGHT_WORDS; i++) begin
      write_w[i] = (state_q == LOAD_W) && valid && (w_q == WW'(i));
    end
    for (int i = 0; i < ACT_WORDS; i++) begin
      write_a[i] = (state_q == MAC) && valid && (w_q == WW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      state_q <= IDLE;
      w_q     <= '0;
      dc_q    <= '0;
      ci_q    <= '0;
      ky_q    <= '0;
      kx_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      co_q    <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      dc_q    <= dc_d;
      ci_q    <= ci_d;
      ky_q    <= ky_d;
      kx_q    <= kx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      co_q    <= co_d;
    end
  end

  assign running               = (state_q != IDLE);
  assign mac_accumulate_with_0 = mac_valid && first_s;
  assign mem_re                = mac_valid && !first_s;
  assign mem_read_addr = LOG2_OF_MEM_HEIGHT'(psum_addr(32'(x_q), 32'(y_q), 32'(co_q),
                          32'(FEATURE_MAP_HEIGHT), 32'(OUTPUT_NB_CHANNELS)));

  ctrl_delay_line #(.WIDTH(DLW), .DEPTH(MAC_LATENCY)) u_delay (
    .clk   (clk),
    .clr_n (arst_n_in),
    .din   ({x_q, y_q, co_q, tap_last_s, mac_valid}),
    .dout  (dl_out_s)
  );

  assign {dl_x_s, dl_y_s, dl_co_s, dl_last_s, dl_v_s} = dl_out_s;
  assign mem_we         = dl_v_s && !dl_last_s;
  assign output_valid   = dl_v_s && dl_last_s;
  assign output_x       = 32'(dl_x_s);
  assign output_y       = 32'(dl_y_s);
  assign output_ch      = 32'(dl_co_s);
  assign mem_write_addr = LOG2_OF_MEM_HEIGHT'(psum_addr(32'(dl_x_s), 32'(dl_y_s), 32'(dl_co_s),
                           32'(FEATURE_MAP_HEIGHT), 32'(OUTPUT_NB_CHANNELS)));

`ifdef CONV_LOOP_CTRL_PERF_EN
  logic [31:0] busy_q, busy_d, stall_q, stall_d;

  // Both counters restart on an accepted start and stick at all-ones.
  always_comb begin
    busy_d  = busy_q;
    stall_d = stall_q;
    if ((state_q == IDLE) && start) begin
      busy_d  = 32'd0;
      stall_d = 32'd0;
    end else begin
      if (running && (busy_q != 32'hFFFF_FFFF)) begin
        busy_d = busy_q + 32'd1;
      end else begin
        busy_d = busy_q;
      end
      if (ready && !valid && (stall_q != 32'hFFFF_FFFF)) begin
        stall_d = stall_q + 32'd1;
      end else begin
        stall_d = stall_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      busy_q  <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign perf_busy  = busy_q;
  assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// Scoreboard bench for conv_loop_ctrl: a 2x2x2x2 K=1 instance and a K=3, 1-word-weight/3-word-act instance.
`timescale 1ns/1ps
module tb_conv_loop_ctrl;

  localparam int LA = 5;
  localparam int LB = 3;

  typedef struct { logic acc0; logic re; logic [31:0] raddr; } mac_exp_t;
  typedef struct { logic last; logic [31:0] x; logic [31:0] y; logic [31:0] ch; logic [31:0] waddr; } out_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  logic rst_n;
  logic start_a, valid_a, running_a, ready_a, mac_valid_a, acc0_a, mem_re_a, mem_we_a, ov_a;
  logic [1:0] write_w_a, write_a_a;
  logic [19:0] raddr_a, waddr_a;
  logic [31:0] ox_a, oy_a, och_a;
  logic start_b, valid_b, running_b, ready_b, mac_valid_b, acc0_b, mem_re_b, mem_we_b, ov_b;
  logic [0:0] write_w_b;
  logic [2:0] write_a_b;
  logic [19:0] raddr_b, waddr_b;
  logic [31:0] ox_b, oy_b, och_b;
`ifdef CONV_LOOP_CTRL_PERF_EN
  logic [31:0] perf_busy_a, perf_stall_a, perf_busy_b, perf_stall_b;
`endif

  conv_loop_ctrl #(
    .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .INPUT_NB_CHANNELS(2), .OUTPUT_NB_CHANNELS(2),
    .KERNEL_SIZE(1), .WEIGHT_WORDS(2), .ACT_WORDS(2), .MAC_LATENCY(LA), .LOG2_OF_MEM_HEIGHT(20)
  ) dut_a (
    .clk(clk), .arst_n_in(rst_n), .start(start_a), .running(running_a), .valid(valid_a),
    .ready(ready_a), .write_w(write_w_a), .write_a(write_a_a), .mac_valid(mac_valid_a),
    .mac_accumulate_with_0(acc0_a), .mem_re(mem_re_a), .mem_read_addr(raddr_a),
    .mem_we(mem_we_a), .mem_write_addr(waddr_a), .output_valid(ov_a),
    .output_x(ox_a), .output_y(oy_a), .output_ch(och_a)
`ifdef CONV_LOOP_CTRL_PERF_EN
    , .perf_busy(perf_busy_a), .perf_stall(perf_stall_a)
`endif
  );

  conv_loop_ctrl #(
    .FEATURE_MAP_WIDTH(1), .FEATURE_MAP_HEIGHT(1), .INPUT_NB_CHANNELS(1), .OUTPUT_NB_CHANNELS(1),
    .KERNEL_SIZE(3), .WEIGHT_WORDS(1), .ACT_WORDS(3), .MAC_LATENCY(LB), .LOG2_OF_MEM_HEIGHT(20)
  ) dut_b (
    .clk(clk), .arst_n_in(rst_n), .start(start_b), .running(running_b), .valid(valid_b),
    .ready(ready_b), .write_w(write_w_b), .write_a(write_a_b), .mac_valid(mac_valid_b),
    .mac_accumulate_with_0(acc0_b), .mem_re(mem_re_b), .mem_read_addr(raddr_b),
    .mem_we(mem_we_b), .mem_write_addr(waddr_b), .output_valid(ov_b),
    .output_x(ox_b), .output_y(oy_b), .output_ch(och_b)
`ifdef CONV_LOOP_CTRL_PERF_EN
    , .perf_busy(perf_busy_b), .perf_stall(perf_stall_b)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard state
  mac_exp_t mac_q_a[$], mac_q_b[$];
  out_exp_t out_q_a[$], out_q_b[$];
  int tq_a[$], tq_b[$];
  bit sb_en_a = 1'b0, sb_en_b = 1'b0;
  int n_mac_a = 0, n_we_a = 0, n_ov_a = 0, n_wl_a = 0, n_run_a = 0, mac_idx_a = 0;
  int n_mac_b = 0, n_we_b = 0, n_ov_b = 0, n_wl_b = 0, n_run_b = 0, walk_b = 0;

  // Monitor A
  initial forever begin
    mac_exp_t m;
    out_exp_t o;
    int t;
    @(negedge clk);
    if (running_a) n_run_a++;
    if (write_w_a[1]) n_wl_a++;
    if (mem_we_a) n_we_a++;
    if (ov_a) n_ov_a++;
    if (mac_valid_a) begin
      n_mac_a++;
      if (sb_en_a) begin
        if (mac_q_a.size() == 0) check("a_mac_unexpected", 32'd1, 32'd0);
        else begin
          m = mac_q_a.pop_front();
          check("a_acc0", 32'(acc0_a), 32'(m.acc0));
          check("a_mem_re", 32'(mem_re_a), 32'(m.re));
          check("a_raddr", 32'(raddr_a), m.raddr);
          if (mac_idx_a == 5) check("a_raddr_x1y0c1", 32'(raddr_a), 32'd5);
          mac_idx_a++;
          tq_a.push_back(cyc);
        end
      end
    end
    if ((mem_we_a || ov_a) && sb_en_a) begin
      if (out_q_a.size() == 0 || tq_a.size() == 0) check("a_out_unexpected", 32'd1, 32'd0);
      else begin
        o = out_q_a.pop_front();
        t = tq_a.pop_front();
        check("a_out_latency", 32'(cyc - t), 32'(LA));
        check("a_out_kind", 32'({mem_we_a, ov_a}), o.last ? 32'd1 : 32'd2);
        check("a_waddr", 32'(waddr_a), o.waddr);
        check("a_out_x", ox_a, o.x);
        check("a_out_y", oy_a, o.y);
        check("a_out_ch", och_a, o.ch);
      end
    end
  end

  // Monitor B
  initial forever begin
    mac_exp_t m;
    out_exp_t o;
    int t;
    logic [2:0] walk_exp;
    @(negedge clk);
    if (running_b) n_run_b++;
    if (write_w_b[0]) n_wl_b++;
    if (mem_we_b) n_we_b++;
    if (ov_b) n_ov_b++;
    if (mac_valid_b) n_mac_b++;
    if (sb_en_b) begin
      if (write_a_b != 3'b000) begin
        walk_exp = 3'b001 << walk_b;
        check("b_write_a_walk", 32'(write_a_b), 32'(walk_exp));
        check("b_mac_on_last_word", 32'(mac_valid_b), (walk_b == 2) ? 32'd1 : 32'd0);
        walk_b = (walk_b + 1) % 3;
      end else begin
        check("b_mac_without_strobe", 32'(mac_valid_b), 32'd0);
      end
      if (mac_valid_b) begin
        if (mac_q_b.size() == 0) check("b_mac_unexpected", 32'd1, 32'd0);
        else begin
          m = mac_q_b.pop_front();
          check("b_acc0", 32'(acc0_b), 32'(m.acc0));
          check("b_mem_re", 32'(mem_re_b), 32'(m.re));
          check("b_raddr", 32'(raddr_b), m.raddr);
          tq_b.push_back(cyc);
        end
      end
      if (mem_we_b || ov_b) begin
        if (out_q_b.size() == 0 || tq_b.size() == 0) check("b_out_unexpected", 32'd1, 32'd0);
        else begin
          o = out_q_b.pop_front();
          t = tq_b.pop_front();
          check("b_out_latency", 32'(cyc - t), 32'(LB));
          check("b_out_kind", 32'({mem_we_b, ov_b}), o.last ? 32'd1 : 32'd2);
          check("b_waddr", 32'(waddr_b), o.waddr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model_a();
    int addr;
    for (int ci = 0; ci < 2; ci++)
      for (int x = 0; x < 2; x++)
        for (int y = 0; y < 2; y++)
          for (int co = 0; co < 2; co++) begin
            addr = (x * 2 + y) * 2 + co;
            mac_q_a.push_back('{acc0: (ci == 0), re: (ci != 0), raddr: 32'(addr)});
            out_q_a.push_back('{last: (ci == 1), x: 32'(x), y: 32'(y), ch: 32'(co), waddr: 32'(addr)});
          end
  endtask

  task automatic wait_idle(input bit is_b, input string name);
    int n = 0;
    while ((is_b ? running_b : running_a) && n < 400) begin
      tick();
      n++;
    end
    check(name, (n < 400) ? 32'd1 : 32'd0, 32'd1);
    tick();
    tick();
  endtask

  initial begin
    int s_mac, s_we, s_ov, s_wl, s_run, n;
    rst_n = 1'b0; start_a = 1'b0; valid_a = 1'b0; start_b = 1'b0; valid_b = 1'b0;
    repeat (3) tick();
    check("rst_running_a", 32'(running_a), 32'd0);
    check("rst_ready_a", 32'(ready_a), 32'd0);
    check("rst_mac_valid_a", 32'(mac_valid_a), 32'd0);
    check("rst_mem_re_a", 32'(mem_re_a), 32'd0);
    check("rst_mem_we_a", 32'(mem_we_a), 32'd0);
    check("rst_output_valid_a", 32'(ov_a), 32'd0);
    check("rst_raddr_a", 32'(raddr_a), 32'd0);
    check("rst_waddr_a", 32'(waddr_a), 32'd0);
    check("rst_output_x_a", ox_a, 32'd0);
    check("rst_running_b", 32'(running_b), 32'd0);
`ifdef CONV_LOOP_CTRL_PERF_EN
    check("rst_perf_busy_a", perf_busy_a, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Run 1: full nest, valid always high
    s_mac = n_mac_a; s_we = n_we_a; s_ov = n_ov_a; s_wl = n_wl_a; s_run = n_run_a;
    push_model_a(); mac_idx_a = 0; sb_en_a = 1'b1; valid_a = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_idle(1'b0, "a_run1_timeout");
    check("a_run1_mac_count", 32'(n_mac_a - s_mac), 32'd16);
    check("a_run1_we_count", 32'(n_we_a - s_we), 32'd8);
    check("a_run1_ov_count", 32'(n_ov_a - s_ov), 32'd8);
    check("a_run1_weight_loads", 32'(n_wl_a - s_wl), 32'd2);
    check("a_run1_running_cycles", 32'(n_run_a - s_run), 32'd42);
    check("a_run1_mac_q_empty", 32'(mac_q_a.size()), 32'd0);
    check("a_run1_out_q_empty", 32'(out_q_a.size()), 32'd0);
`ifdef CONV_LOOP_CTRL_PERF_EN
    check("a_run1_perf_busy", perf_busy_a, 32'd42);
    check("a_run1_perf_stall", perf_stall_a, 32'd0);
`endif

    // Run 2: three-cycle stall between act word 0 and act word 1
    s_mac = n_mac_a; s_run = n_run_a;
    push_model_a(); mac_idx_a = 0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (write_a_a != 2'b01 && n < 100);
    check("a_stall_find_word0", (n < 100) ? 32'd1 : 32'd0, 32'd1);
    tick(); valid_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("a_stall_ready", 32'(ready_a), 32'd1);
      check("a_stall_write_a", 32'(write_a_a), 32'd0);
      check("a_stall_write_w", 32'(write_w_a), 32'd0);
      check("a_stall_mac_valid", 32'(mac_valid_a), 32'd0);
    end
    tick(); valid_a = 1'b1;
    @(negedge clk);
    check("a_stall_w_held", 32'(write_a_a), 32'd2);
    wait_idle(1'b0, "a_run2_timeout");
    check("a_run2_mac_count", 32'(n_mac_a - s_mac), 32'd16);
    check("a_run2_running_cycles", 32'(n_run_a - s_run), 32'd45);
    check("a_run2_mac_q_empty", 32'(mac_q_a.size()), 32'd0);
    check("a_run2_out_q_empty", 32'(out_q_a.size()), 32'd0);
`ifdef CONV_LOOP_CTRL_PERF_EN
    check("a_run2_perf_stall", perf_stall_a, 32'd3);
    check("a_run2_perf_busy", perf_busy_a, 32'd45);
`endif

    // Run 3: reset mid-MAC with results still in the delay line
    sb_en_a = 1'b0;
    mac_q_a.delete(); out_q_a.delete(); tq_a.delete();
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (10) tick();
    check("a_pre_reset_running", 32'(running_a), 32'd1);
    rst_n = 1'b0;
    tick();
    check("a_abort_running", 32'(running_a), 32'd0);
    check("a_abort_ready", 32'(ready_a), 32'd0);
    check("a_abort_mem_we", 32'(mem_we_a), 32'd0);
    check("a_abort_output_valid", 32'(ov_a), 32'd0);
    rst_n = 1'b1;
    repeat (LA + 1) begin
      @(negedge clk);
      check("a_post_reset_mem_we", 32'(mem_we_a), 32'd0);
      check("a_post_reset_output_valid", 32'(ov_a), 32'd0);
      check("a_post_reset_running", 32'(running_a), 32'd0);
    end
    tick();

    // Run 4: instance B, 3x3 kernel, single output position
    s_mac = n_mac_b; s_we = n_we_b; s_ov = n_ov_b; s_wl = n_wl_b; s_run = n_run_b;
    for (int i = 0; i < 9; i++) begin
      mac_q_b.push_back('{acc0: (i == 0), re: (i != 0), raddr: 32'd0});
      out_q_b.push_back('{last: (i == 8), x: 32'd0, y: 32'd0, ch: 32'd0, waddr: 32'd0});
    end
    walk_b = 0; sb_en_b = 1'b1; valid_b = 1'b1;
    start_b = 1'b1; tick(); start_b = 1'b0;
    wait_idle(1'b1, "b_run_timeout");
    check("b_mac_count", 32'(n_mac_b - s_mac), 32'd9);
    check("b_we_count", 32'(n_we_b - s_we), 32'd8);
    check("b_ov_count", 32'(n_ov_b - s_ov), 32'd1);
    check("b_weight_loads", 32'(n_wl_b - s_wl), 32'd9);
    check("b_running_cycles", 32'(n_run_b - s_run), 32'd40);
    check("b_mac_q_empty", 32'(mac_q_b.size()), 32'd0);
    check("b_out_q_empty", 32'(out_q_b.size()), 32'd0);
    check("b_final_output_x", ox_b, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_loop_ctrl.md
Name: conv_loop_ctrl

Overview:
- Parametrised loop-nest controller for the convolution accelerator; successor to the fixed 2-word/5-stage controller.
- Sequences weight and activation operand fetch over an explicit kernel window (ky, kx), with configurable operand word counts and MAC pipeline depth.
- Drives partial-sum memory read/write with linear addressing and emits output coordinates.
- Sits between the host stream handshake and the MAC datapath/psum SRAM.

Parameters:
FEATURE_MAP_WIDTH, 16, spatial x extent
FEATURE_MAP_HEIGHT, 16, spatial y extent
INPUT_NB_CHANNELS, 8, input channels (outermost loop)
OUTPUT_NB_CHANNELS, 8, output channels
KERNEL_SIZE, 3, kernel taps per dimension
WEIGHT_WORDS, 2, stream words per weight load (>=1)
ACT_WORDS, 2, stream words per activation operand (>=1)
MAC_LATENCY, 5, cycles from mac_valid to result on datapath output (>=1)
LOG2_OF_MEM_HEIGHT, 20, psum address width

Ports:
clk  in  1  clock
arst_n_in  in  1  reset; synchronous, active-low, sampled on rising clk
start  in  1  begin layer; sampled only in IDLE
running  out  1  high in every state except IDLE
valid  in  1  host word valid
ready  out  1  controller accepts word (LOAD_W, MAC states)
write_w  out  WEIGHT_WORDS  one-hot weight register strobe
write_a  out  ACT_WORDS  one-hot activation register strobe
mac_valid  out  1  full operand set present; one pulse per MAC
mac_accumulate_with_0  out  1  with mac_valid: first contribution to this psum
mem_re  out  1  psum read strobe
mem_read_addr  out  LOG2_OF_MEM_HEIGHT  psum read address
mem_we  out  1  psum write strobe
mem_write_addr  out  LOG2_OF_MEM_HEIGHT  psum write address
output_valid  out  1  final sum on datapath output
output_x, output_y, output_ch  out  32 each  coordinates of final sum

Behaviour:
- Loop order, outer to inner: ch_in, ky, kx, x, y, ch_out. Each counter is $clog2(extent) wide (min 1) and wraps to 0 at extent-1.
- Weights are loaded once per (ch_in, ky, kx) tap, before its spatial sweep. One MAC is performed per (x, y, ch_out).
- States:
  - IDLE: start -> LOAD_W.
  - LOAD_W: word counter w, 0..WEIGHT_WORDS-1. After the last weight word -> MAC.
  - MAC: word counter w, 0..ACT_WORDS-1. After the last act word, if the innermost loops wrapped and the loop nest is not finished -> LOAD_W; else stay in MAC. On the final MAC of the nest -> DRAIN.
  - DRAIN: exactly MAC_LATENCY cycles -> DONE.
  - DONE: 1 cycle -> IDLE.
- Transfers:
  - Transfer = valid && ready. ready=1 only in LOAD_W and MAC.
  - write_w[w] / write_a[w] are combinationally high in the matching state, and only while valid. Without valid, w holds and the state holds (stall).
- MAC pulse: mac_valid is a 1-cycle pulse on transfer of act word ACT_WORDS-1. The loop counters advance on that same edge.
- first = (ch_in==0 && ky==0 && kx==0); last = all of ch_in, ky, kx at extent-1.
  - mac_accumulate_with_0 = first, qualified by mac_valid.
  - mem_re = mac_valid && !first.
  - mem_read_addr = (x*FEATURE_MAP_HEIGHT + y)*OUTPUT_NB_CHANNELS + ch_out, truncated to LOG2_OF_MEM_HEIGHT.
- Delay line: a MAC_LATENCY-deep shift register carries {x, y, ch_out, last, mac_valid}. At its tap:
  - mem_we = dv && !last
  - output_valid = dv && last
  - mem_write_addr uses the same formula on the delayed coordinates
  - output_x/y/ch = delayed coordinates, zero-extended
- The delay line shifts every cycle, including during stalls. A bubble is inserted when mac_valid=0.
- Reset values: state IDLE, all counters 0, delay line 0. All outputs 0 except the addresses, which reset to 0 by formula.
- start while running is ignored.
- Synchronous reset in any state aborts: next cycle is IDLE with counters and delay line cleared, and no mem_we or output_valid fires after reset.
- Single-word case: WEIGHT_WORDS=1 or ACT_WORDS=1 is legal; the w counter is then a constant 0.

Optional Feature:
- Macro: CONV_LOOP_CTRL_PERF_EN.
- Defined: adds outputs perf_busy (32b) and perf_stall (32b).
  - perf_busy counts cycles with running=1.
  - perf_stall counts LOAD_W/MAC cycles with valid=0.
  - Both clear on start accepted and on reset, and saturate at 2^32-1.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package conv_ctrl_pkg: state enum (IDLE, LOAD_W, MAC, DRAIN, DONE) and a psum_addr function (x, y, ch, dims).
- Sub-module ctrl_delay_line: parametrised width/depth shift register with synchronous clear, used for the MAC_LATENCY tap.

Test Plan:
- Config W=H=IN=OUT=2, K=1, WEIGHT_WORDS=ACT_WORDS=2, MAC_LATENCY=5, valid held 1, start pulse:
  - 16 mac_valid, 8 mem_we, 8 output_valid, 2 weight loads.
  - running high exactly 42 cycles.
- Same config: check the read address at x=1, y=0, ch_out=1 is 5. Each output_valid matches its coordinates 5 cycles after the corresponding mac_valid.
- Same config, valid low for 3 cycles mid-MAC:
  - ready stays 1, no strobe, w holds.
  - perf_stall=3 (macro on); running lengthens by 3.
- K=3, IN=1, W=H=OUT=1:
  - mac_accumulate_with_0 only on the first MAC.
  - mem_re on MACs 2-9, output_valid once, mem_we 8 times.
- Assert reset during MAC at an arbitrary cycle: next cycle is IDLE, running=0, and no mem_we or output_valid for the following MAC_LATENCY cycles.
- WEIGHT_WORDS=1, ACT_WORDS=3: write_a walks 001, 010, 100; mac_valid pulses on 100 only.
